// File: rtl/port_controller_pkg.sv
// Shared sizing and request-decode types for the port controller and its FIFOs.
package port_controller_pkg;
  localparam int WORD_SIZE          = 16;
  localparam int HALT_PORT          = 0;
  localparam int FIFO_DEPTH_DEFAULT = 4;
  localparam int NUM_PORTS_DEFAULT  = 4;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_GET  = 2'd1,
    REQ_SET  = 2'd2
  } req_kind_e;
endpackage

// File: rtl/port_controller_fifo.sv
// Per-channel output FIFO: circular buffer with registered count, full/empty and head.
module port_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/port_controller.sv
// CPU port controller: request decode, halt port, per-channel output FIFOs and
// one-entry input holding registers, with stall/done/bad_access reporting.
module port_controller
  import port_controller_pkg::*;
#(
  parameter int NUM_PORTS  = NUM_PORTS_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WORD_SIZE-1:0]           portaddr,
  input  logic [WORD_SIZE-1:0]           portval,
  input  logic                           get_enable,
  input  logic                           set_enable,
  output logic [WORD_SIZE-1:0]           portout,
  output logic                           done,
  output logic                           stall,
  output logic                           bad_access,
  output logic                           halted,
  output logic [NUM_PORTS-1:0]           out_valid,
  output logic [NUM_PORTS*WORD_SIZE-1:0] out_data,
  input  logic [NUM_PORTS-1:0]           out_ready,
  input  logic [NUM_PORTS-1:0]           in_valid,
  input  logic [NUM_PORTS*WORD_SIZE-1:0] in_data,
  output logic [NUM_PORTS-1:0]           in_ready
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [WORD_SIZE-1:0] portout_q, portout_d;
  logic                 done_q, done_d, bad_q, bad_d, halted_q, halted_d;
  logic [WORD_SIZE-1:0] hold_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] hold_valid_q, capture_vec, consume_vec, push_vec;
  logic [NUM_PORTS-1:0] fifo_full;
  logic                 addr_ok;
  logic [PW-1:0]        idx;
  req_kind_e            req_kind;

  assign addr_ok     = (portaddr < WORD_SIZE'(NUM_PORTS));
  assign idx         = portaddr[PW-1:0];
  assign in_ready    = {~hold_valid_q[NUM_PORTS-1:1], 1'b0};
  assign capture_vec = in_valid & in_ready;
  assign portout     = portout_q;
  assign done        = done_q;
  assign bad_access  = bad_q;
  assign halted      = halted_q;

  // Channel 0 is the halt port and has no data path.
  assign out_valid[0]            = 1'b0;
  assign out_data[WORD_SIZE-1:0] = '0;
  assign fifo_full[0]            = 1'b0;
  wire unused_out_ready0 = out_ready[0];

  for (genvar p = 1; p < NUM_PORTS; p++) begin : g_chan
    logic fifo_empty;
    port_fifo #(.WIDTH(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_vec[p]),
      .pop_i   (out_ready[p]),
      .wdata_i (portval),
      .full_o  (fifo_full[p]),
      .empty_o (fifo_empty),
      .head_o  (out_data[p*WORD_SIZE +: WORD_SIZE])
    );
    assign out_valid[p] = ~fifo_empty;
  end

  // A request is not re-accepted in its done cycle, so one held request gives one done.
  always_comb begin
    req_kind    = REQ_NONE;
    stall       = 1'b0;
    push_vec    = '0;
    consume_vec = '0;
    done_d      = 1'b0;
    bad_d       = 1'b0;
    halted_d    = halted_q;
    portout_d   = portout_q;
    if (!halted_q && !done_q) begin
      if (get_enable)      req_kind = REQ_GET;
      else if (set_enable) req_kind = REQ_SET;
    end
    case (req_kind)
      REQ_GET: begin
        if (!addr_ok || idx == PW'(HALT_PORT)) begin
          done_d    = 1'b1;
          bad_d     = ~addr_ok;
          portout_d = '0;
        end else if (hold_valid_q[idx]) begin
          done_d           = 1'b1;
          consume_vec[idx] = 1'b1;
          portout_d        = hold_q[idx];
        end else begin
          stall = 1'b1;
        end
      end
      REQ_SET: begin
        if (!addr_ok) begin
          done_d = 1'b1;
          bad_d  = 1'b1;
        end else if (idx == PW'(HALT_PORT)) begin
          done_d   = 1'b1;
          halted_d = 1'b1;
        end else if (!fifo_full[idx]) begin
          done_d        = 1'b1;
          push_vec[idx] = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      portout_q    <= '0;
      done_q       <= 1'b0;
      bad_q        <= 1'b0;
      halted_q     <= 1'b0;
      hold_valid_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) hold_q[p] <= '0;
    end else begin
      portout_q    <= portout_d;
      done_q       <= done_d;
      bad_q        <= bad_d;
      halted_q     <= halted_d;
      hold_valid_q <= (hold_valid_q & ~consume_vec) | capture_vec;
      for (int p = 0; p < NUM_PORTS; p++)
        if (capture_vec[p]) hold_q[p] <= in_data[p*WORD_SIZE +: WORD_SIZE];
    end
  end
endmodule

// File: tb/tb_port_controller.sv
// Directed bench for port_controller: FIFO writes/drain, input capture, arbitration,
// address errors and halt, with expected data queued at stimulus time.
module tb_port_controller;
  import port_controller_pkg::*;

  localparam int NP = 4;
  localparam int W  = WORD_SIZE;
  localparam int D  = 4;

  logic              clk, rst_n;
  logic [W-1:0]      portaddr, portval, portout;
  logic              get_enable, set_enable, done, stall, bad_access, halted;
  logic [NP-1:0]     out_valid, out_ready, in_valid, in_ready;
  logic [NP*W-1:0]   out_data, in_data;

  port_controller #(.NUM_PORTS(NP), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .portaddr   (portaddr),
    .portval    (portval),
    .get_enable (get_enable),
    .set_enable (set_enable),
    .portout    (portout),
    .done       (done),
    .stall      (stall),
    .bad_access (bad_access),
    .halted     (halted),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           checks = 0;
  int           passed = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rd_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] head(input int p);
    return out_data[p*W +: W];
  endfunction

  // driver: one CPU request held until done or the cycle budget runs out
  task automatic cpu_op(input bit is_get, input logic [W-1:0] addr, input logic [W-1:0] val,
                        output bit got, output int waited);
    got    = 1'b0;
    waited = 0;
    @(negedge clk);
    portaddr   = addr;
    portval    = val;
    get_enable = is_get;
    set_enable = !is_get;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) begin
        got = 1'b1;
        break;
      end
      waited++;
    end
    @(negedge clk);
    get_enable = 1'b0;
    set_enable = 1'b0;
  endtask

  // driver + scoreboard: drain channel p, comparing each head with exp_q
  task automatic drain(input int p, input int budget);
    @(negedge clk);
    out_ready[p] = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      chk("drain_valid", out_valid[p], 1);
      chk("drain_data", head(p), exp_q.pop_front());
      @(negedge clk);
    end
    out_ready[p] = 1'b0;
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_valid_low", out_valid[p], 0);
  endtask

  bit           got;
  int           waited;
  logic [W-1:0] rv;

  initial begin
    rst_n = 1'b0; portaddr = '0; portval = '0; get_enable = 1'b0; set_enable = 1'b0;
    out_ready = '0; in_valid = '0; in_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset arriving mid-set to port 2
    @(negedge clk);
    portaddr = 2; portval = 16'h1234; set_enable = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_portout", portout, 0);
    chk("rst_bad", bad_access, 0);
    chk("rst_in_ready", in_ready, 4'b1110);
    @(negedge clk);
    set_enable = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_fifo2_empty", out_valid[2], 0);

    // fill FIFO 1, then a write to a full FIFO
    for (int v = 5; v <= 8; v++) begin
      cpu_op(1'b0, 1, W'(v), got, waited);
      chk("fill_done", got, 1);
      chk("fill_latency", waited, 0);
      exp_q.push_back(W'(v));
    end
    chk("fill_out_valid", out_valid[1], 1);
    @(negedge clk);
    portaddr = 1; portval = 9; set_enable = 1'b1;
    #1 chk("full_stall", stall, 1);
    @(posedge clk); #1;
    chk("full_no_done", done, 0);
    @(negedge clk);
    out_ready[1] = 1'b1;
    #1;
    chk("pop_head", head(1), exp_q.pop_front());
    chk("pop_same_cycle_still_stall", stall, 1);
    @(posedge clk); #1;
    chk("pop_cycle_no_done", done, 0);
    @(negedge clk);
    out_ready[1] = 1'b0;
    #1 chk("after_pop_no_stall", stall, 0);
    @(posedge clk); #1;
    chk("write9_done", done, 1);
    exp_q.push_back(9);
    @(negedge clk);
    set_enable = 1'b0;
    @(posedge clk); #1;
    chk("done_single_pulse", done, 0);
    drain(1, 10);

    // get from an empty holding register, then capture
    @(negedge clk);
    portaddr = 3; get_enable = 1'b1;
    #1;
    chk("get_empty_stall", stall, 1);
    chk("in_ready3_idle", in_ready[3], 1);
    @(posedge clk); #1;
    chk("get_empty_no_done", done, 0);
    @(negedge clk);
    in_valid[3] = 1'b1;
    in_data[3*W +: W] = 42;
    rd_q.push_back(42);
    @(posedge clk); #1;
    chk("in_ready3_full", in_ready[3], 0);
    chk("capture_cycle_no_done", done, 0);
    @(negedge clk);
    in_valid[3] = 1'b0;
    #1 chk("held_no_stall", stall, 0);
    @(posedge clk); #1;
    chk("get3_done", done, 1);
    chk("get3_data", portout, rd_q.pop_front());
    chk("in_ready3_back", in_ready[3], 1);
    @(negedge clk);
    get_enable = 1'b0;

    // get and set together on port 2: the read wins
    rv = W'($urandom_range(1, 16'hFFFF));
    @(negedge clk);
    in_valid[2] = 1'b1;
    in_data[2*W +: W] = rv;
    rd_q.push_back(rv);
    @(negedge clk);
    in_valid[2] = 1'b0;
    portaddr = 2; portval = 16'h0055; get_enable = 1'b1; set_enable = 1'b1;
    @(posedge clk); #1;
    chk("arb_done", done, 1);
    chk("arb_data", portout, rd_q.pop_front());
    @(negedge clk);
    get_enable = 1'b0; set_enable = 1'b0;
    #1 chk("arb_fifo2_empty", out_valid[2], 0);
    @(posedge clk); #1;
    chk("arb_fifo2_still_empty", out_valid[2], 0);

    // out-of-range port
    cpu_op(1'b0, 7, 16'h00AB, got, waited);
    chk("bad_set_done", got, 1);
    chk("bad_set_flag", bad_access, 1);
    chk("bad_set_latency", waited, 0);
    chk("bad_set_no_push", out_valid, 0);
    cpu_op(1'b1, 7, 16'h0000, got, waited);
    chk("bad_get_done", got, 1);
    chk("bad_get_flag", bad_access, 1);
    chk("bad_get_data", portout, 0);

    // halt
    cpu_op(1'b0, 1, 16'h00A1, got, waited);
    chk("pre_halt_done", got, 1);
    chk("good_access_no_bad", bad_access, 0);
    exp_q.push_back(16'h00A1);
    cpu_op(1'b0, 0, 16'h0000, got, waited);
    chk("halt_done", got, 1);
    chk("halted_set", halted, 1);
    if (halted) $display("Machine halting");
    @(negedge clk);
    portaddr = 1; portval = 16'h00B2; set_enable = 1'b1;
    #1 chk("halted_no_stall", stall, 0);
    set_enable = 1'b0;
    cpu_op(1'b0, 1, 16'h00B2, got, waited);
    chk("halted_set_ignored", got, 0);
    @(negedge clk);
    in_valid[3] = 1'b1;
    in_data[3*W +: W] = 16'h0007;
    @(negedge clk);
    in_valid[3] = 1'b0;
    chk("halted_capture", in_ready[3], 0);
    cpu_op(1'b1, 3, 16'h0000, got, waited);
    chk("halted_get_ignored", got, 0);
    chk("halted_hold_kept", in_ready[3], 0);
    drain(1, 10);
    chk("halted_sticky", halted, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
